// File: rtl/rv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory
// responder (slave). Two phases: an address phase (mem_addr_vld /
// mem_addr_rsp) followed by a data phase (mem_wdata_vld for stores,
// completed by mem_data_rsp, with mem_rdata valid in that cycle for loads).
//   mem_addr_vld  M->S  address phase valid
//   mem_addr      M->S  byte address
//   mem_op        M->S  1=write, 0=read
//   mem_op_size   M->S  0/1/2 = byte/half/word
//   mem_addr_rsp  S->M  address accepted this cycle
//   mem_wdata_vld M->S  write data valid
//   mem_wdata     M->S  write data, low-justified, unshifted
//   mem_rdata     S->M  word-aligned read word
//   mem_data_rsp  S->M  data phase complete this cycle
interface rv_lsu_if;
    logic        mem_addr_vld;
    logic [31:0] mem_addr;
    logic        mem_op;
    logic [1:0]  mem_op_size;
    logic        mem_addr_rsp;
    logic        mem_wdata_vld;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_data_rsp;

    modport master (
        output mem_addr_vld, mem_addr, mem_op, mem_op_size, mem_wdata_vld, mem_wdata,
        input  mem_addr_rsp, mem_rdata, mem_data_rsp
    );

    modport slave (
        input  mem_addr_vld, mem_addr, mem_op, mem_op_size, mem_wdata_vld, mem_wdata,
        output mem_addr_rsp, mem_rdata, mem_data_rsp
    );
endinterface

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one load or store at a time from execute, checks
// alignment, runs the address then data phase on the memory bus, and returns
// a lane-extracted, sign/zero-extended load result or a store completion.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 request from execute (req_rdy high only in IDLE)
//   resp_*                one-cycle completion pulse to writeback
//   mem                   rv_lsu_if master port to the data memory
// TIMEOUT_CYCLES bounds the wait in each bus phase before a bus error.
module rv_lsu #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_vld,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    rv_lsu_if.master    mem
);
    // One spare bit so the counter can hold TIMEOUT_CYCLES for any value.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   addr_reg, wdata_reg, rdata_reg;
    logic [1:0]    size_reg;
    logic          store_reg, unsigned_reg, err_reg;
    logic [4:0]    rd_reg;
    logic [CW-1:0] cnt_reg;

    logic          accept, misaligned, expired;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_ext;

    assign accept     = req_vld && (state_reg == IDLE);
    assign misaligned = (req_size == 2'd3)
                     || ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign expired    = (cnt_reg == CW'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a handshake takes priority over an expiring counter.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = misaligned ? RESP : ADDR;
            ADDR: begin
                if (mem.mem_addr_rsp) state_next = DATA;
                else if (expired)     state_next = RESP;
            end
            DATA: begin
                if (mem.mem_data_rsp) state_next = RESP;
                else if (expired)     state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_rdy           = 1'b0;
        resp_vld          = 1'b0;
        resp_err          = 1'b0;
        resp_rdata        = 32'd0;
        resp_rd           = 5'd0;
        mem.mem_addr_vld  = 1'b0;
        mem.mem_addr      = 32'd0;
        mem.mem_op        = 1'b0;
        mem.mem_op_size   = 2'd0;
        mem.mem_wdata_vld = 1'b0;
        mem.mem_wdata     = 32'd0;
        case (state_reg)
            IDLE: req_rdy = 1'b1;
            ADDR: begin
                mem.mem_addr_vld = 1'b1;
                mem.mem_addr     = addr_reg;
                mem.mem_op       = store_reg;
                mem.mem_op_size  = size_reg;
            end
            DATA: begin
                // Address/op stay visible so the responder can track the access.
                mem.mem_addr      = addr_reg;
                mem.mem_op        = store_reg;
                mem.mem_op_size   = size_reg;
                mem.mem_wdata_vld = store_reg;
                mem.mem_wdata     = store_reg ? wdata_reg : 32'd0;
            end
            default: begin
                resp_vld   = 1'b1;
                resp_err   = err_reg;
                resp_rdata = err_reg ? 32'd0 : rdata_reg;
                resp_rd    = rd_reg;
            end
        endcase
    end

    // Lane extraction from the word-aligned read word.
    always_comb begin
        lane_b = mem.mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
        lane_h = mem.mem_rdata[{addr_reg[1], 4'b0000} +: 16];
        case (size_reg)
            2'd0:    load_ext = unsigned_reg ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_ext = unsigned_reg ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // Request latch, error flag and load result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            rdata_reg    <= 32'd0;
            size_reg     <= 2'd0;
            store_reg    <= 1'b0;
            unsigned_reg <= 1'b0;
            err_reg      <= 1'b0;
            rd_reg       <= 5'd0;
        end else begin
            if (accept) begin
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                size_reg     <= req_size;
                store_reg    <= req_store;
                unsigned_reg <= req_unsigned;
                rd_reg       <= req_rd;
                err_reg      <= misaligned;
                rdata_reg    <= 32'd0;
            end
            if ((state_reg == ADDR) && !mem.mem_addr_rsp && expired) begin
                err_reg <= 1'b1;
            end
            if (state_reg == DATA) begin
                if (mem.mem_data_rsp) begin
                    if (!store_reg) rdata_reg <= load_ext;
                end else if (expired) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    // Phase timer: cleared on every state change, so it restarts on entry
    // to ADDR and to DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            cnt_reg <= '0;
        end else if ((state_reg == ADDR) || (state_reg == DATA)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_rv_lsu.sv
module tb_rv_lsu;
    logic        clk;
    logic        rst_n;
    logic        req_vld, req_rdy, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_vld, resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;

    rv_lsu_if mif();

    rv_lsu #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_vld(resp_vld), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .mem(mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- memory responder ----------------
    logic [7:0]  mem [0:255];
    int          a_wait, d_wait;
    int          addr_delay = 0;
    int          data_delay = 0;
    logic        in_data, t_op;
    logic [1:0]  t_size;
    logic [31:0] t_addr;

    assign mif.mem_addr_rsp = mif.mem_addr_vld && (a_wait == addr_delay);
    assign mif.mem_data_rsp = in_data && (d_wait == data_delay);
    assign mif.mem_rdata    = {mem[{t_addr[7:2], 2'd3}], mem[{t_addr[7:2], 2'd2}],
                               mem[{t_addr[7:2], 2'd1}], mem[{t_addr[7:2], 2'd0}]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data <= 1'b0;
            a_wait  <= 0;
            d_wait  <= 0;
            t_op    <= 1'b0;
            t_size  <= 2'd0;
            t_addr  <= 32'd0;
        end else begin
            if (mif.mem_addr_vld && !mif.mem_addr_rsp) a_wait <= a_wait + 1;
            else                                       a_wait <= 0;
            if (mif.mem_addr_vld && mif.mem_addr_rsp) begin
                in_data <= 1'b1;
                d_wait  <= 0;
                t_op    <= mif.mem_op;
                t_size  <= mif.mem_op_size;
                t_addr  <= mif.mem_addr;
            end else if (in_data) begin
                if (mif.mem_data_rsp) begin
                    in_data <= 1'b0;
                    if (t_op) begin
                        for (int i = 0; i < 4; i++) begin
                            if (i < (1 << t_size))
                                mem[t_addr[7:0] + 8'(i)] <= mif.mem_wdata[8*i +: 8];
                        end
                    end
                end else if (resp_vld) begin
                    in_data <= 1'b0;
                end else begin
                    d_wait <= d_wait + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [4:0]  rd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    logic seen_addr = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mif.mem_addr_vld) seen_addr = 1'b1;
            if (rst_n && in_data && t_op && mif.mem_data_rsp)
                chk("store_wdata_vld", {31'd0, mif.mem_wdata_vld}, 32'd1);
            if (resp_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rd=%0d expected none", resp_rd);
                end else begin
                    e = exp_q.pop_front();
                    $display("TXN rd=%0d err=%0b rdata=%h latency=%0d", resp_rd, resp_err,
                             resp_rdata, cyc - e.acc);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
                    chk("latency", cyc - e.acc, e.lat);
                    chk("addr_vld_at_resp", {31'd0, mif.mem_addr_vld}, 32'd0);
                    if (e.err && (e.lat == 1))
                        chk("no_mem_for_misaligned", {31'd0, seen_addr}, 32'd0);
                end
                seen_addr = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd,
                          input logic e, input logic [31:0] expd, input int lat);
        int n;
        @(negedge clk);
        req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd; req_rd = rd; req_vld = 1'b1;
        n = 0;
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        if (!req_rdy) begin
            checks++; errors++;
            $display("FAIL req_rdy_wait: got 0 expected 1 within 50 cycles");
            req_vld = 1'b0;
            return;
        end
        exp_q.push_back('{rd, e, expd, lat, cyc});
        @(negedge clk);
        req_vld = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_wait: got no response expected one within 60 cycles");
            exp_q.delete();
        end
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        e;
        logic [31:0] expd;
    } vec_t;
    vec_t vecs[22];

    initial begin
        int n;
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h8070F0A5, 1'b0, 32'h0};        // preload A5,F0,70,80
        vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h00000000, 1'b0, 32'h0};        // clear 0x20..0x23
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        1'b0, 32'hFFFFFFF0}; // LB
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b0, 32'h000000F0}; // LBU
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFF8070}; // LH
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        1'b0, 32'h00008070}; // LHU
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h8070F0A5}; // LW
        vecs[7]  = '{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        1'b0, 32'h8070F0A5}; // LW, unsigned ignored
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80}; // LB top lane
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        1'b0, 32'h000000A5}; // LBU lane 0
        vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h12345678, 1'b0, 32'h0};        // SB
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 32'h00007800};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h00000000, 1'b0, 32'h0};        // clear again
        vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'hAAAABEEF, 1'b0, 32'h0};        // SH
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 32'hBEEF0000};
        vecs[15] = '{1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, 32'h0};        // SW
        vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h22, 32'h0,        1'b1, 32'h0};        // LW misaligned
        vecs[18] = '{1'b0, 2'd1, 1'b0, 32'h13, 32'h0,        1'b1, 32'h0};        // LH misaligned
        vecs[19] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        1'b1, 32'h0};        // illegal size
        vecs[20] = '{1'b1, 2'd1, 1'b0, 32'h21, 32'h11112222, 1'b1, 32'h0};        // SH misaligned
        vecs[21] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b0, 32'hDEADBEEF}; // unchanged

        rst_n = 1'b0; req_vld = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_resp_vld", {31'd0, resp_vld}, 32'd0);
        chk("rst_addr_vld", {31'd0, mif.mem_addr_vld}, 32'd0);
        chk("rst_wdata_vld", {31'd0, mif.mem_wdata_vld}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);

        for (int i = 0; i < 22; i++)
            do_req(vecs[i].st, vecs[i].sz, vecs[i].un, vecs[i].ad, vecs[i].wd, 5'(i),
                   vecs[i].e, vecs[i].expd, vecs[i].e ? 1 : 3);

        // Address phase never accepted: 16 cycles in ADDR, then error.
        addr_delay = 1000; data_delay = 0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd24, 1'b1, 32'h0, 17);
        // Data phase never completes: 16 cycles in DATA, then error.
        addr_delay = 0; data_delay = 1000;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd25, 1'b1, 32'h0, 18);
        // Handshake on the expiry cycle wins.
        addr_delay = 15; data_delay = 0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd26, 1'b0, 32'h8070F0A5, 18);
        addr_delay = 0; data_delay = 15;
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 5'd27, 1'b0, 32'h00008070, 18);

        // Reset in the data phase of a store aborts it without a write.
        addr_delay = 0; data_delay = 1000;
        @(negedge clk);
        req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h11111111; req_rd = 5'd28; req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        n = 0;
        while (!mif.mem_wdata_vld && n < 10) begin @(negedge clk); n++; end
        chk("wdata_vld_before_rst", {31'd0, mif.mem_wdata_vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wdata_vld", {31'd0, mif.mem_wdata_vld}, 32'd0);
        chk("rst_mid_resp_vld", {31'd0, resp_vld}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data_delay = 0;
        @(negedge clk);
        chk("rst_release_req_rdy", {31'd0, req_rdy}, 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd29, 1'b0, 32'hDEADBEEF, 3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
